uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link_pkg.sv | 39 +++
 rtl/uart_link_if.sv | 20 ++
 rtl/uart_link_rx.sv | 174 +++++++++++++++++
 rtl/uart_link.sv | 160 ++++++++++++++++
 tb/tb_uart_link.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_link_pkg.sv
// uart_link_pkg: state encodings and bit-timing helpers shared by uart_link and uart_link_rx.
// Optional feature macro: UART_LINK_PARITY_EN (even-parity bit between data and stop).
package uart_link_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_LINK_PARITY_EN
        R_PARITY,
`endif
        R_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
`ifdef UART_LINK_PARITY_EN
        T_PARITY,
`endif
        T_STOP,
        T_WAIT
    } tx_state_e;

    // Clocks per serial bit; integer division, the caller guarantees a result of at least 4.
    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud);
        return clock_freq / baud;
    endfunction

`ifdef UART_LINK_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_link_if.sv
// uart_link_if: byte-level handshake between uart_link and the downstream port block.
// master = UART side, slave = port-block side.
interface uart_link_if;
    logic       load;
    logic [7:0] datain;
    logic       rxerr;
    logic       ready;
    logic       enout;
    logic [7:0] dataout;

    modport master (
        output load, datain, rxerr, ready,
        input  enout, dataout
    );

    modport slave (
        input  load, datain, rxerr, ready,
        output enout, dataout
    );
endinterface

// File: rtl/uart_link_rx.sv
// uart_link_rx: serial receiver - rxd synchronizer, RX FSM, datain/load/rxerr outputs.
// Optional feature macro: UART_LINK_PARITY_EN (even-parity bit checked before stop).
module uart_link_rx
    import uart_link_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD       = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       load,
    output logic [7:0] datain,
    output logic       rxerr
);
    localparam int unsigned CPB  = clks_per_bit(CLOCK_FREQ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          from_stop_q, from_stop_d;
    logic          start_seen;
    logic          stop_ok;

`ifdef UART_LINK_PARITY_EN
    logic          par_ok_q, par_ok_d;
    assign stop_ok = rxd_sync_q & par_ok_q;
`else
    assign stop_ok = rxd_sync_q;
`endif

    // A start is a synchronized falling edge; directly after a stop sample a line that is
    // already low is also accepted so a start coinciding with the return to idle is not lost.
    assign start_seen = ~rxd_sync_q & (rxd_prev_q | from_stop_q);

    // Two-flop synchronizer plus one delayed copy for edge detection; resets to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // RX next-state: mid-bit sampling of start, data, optional parity and stop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        load_d      = 1'b0;
        err_d       = 1'b0;
        from_stop_d = 1'b0;
`ifdef UART_LINK_PARITY_EN
        par_ok_d    = par_ok_q;
`endif
        unique case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (start_seen) begin
                    state_d = R_START;
                end
            end
            R_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (rxd_sync_q) begin
                        state_d = R_IDLE;
                    end else begin
                        state_d = R_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_LINK_PARITY_EN
                        state_d = R_PARITY;
`else
                        state_d = R_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_LINK_PARITY_EN
            R_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d    = '0;
                    par_ok_d = (rxd_sync_q == even_parity(shift_q));
                    state_d  = R_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            R_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d       = '0;
                    state_d     = R_IDLE;
                    from_stop_d = 1'b1;
                    if (stop_ok) begin
                        data_d = shift_q;
                        load_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = R_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // RX state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= R_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            from_stop_q <= 1'b0;
`ifdef UART_LINK_PARITY_EN
            par_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            load_q      <= load_d;
            err_q       <= err_d;
            from_stop_q <= from_stop_d;
`ifdef UART_LINK_PARITY_EN
            par_ok_q    <= par_ok_d;
`endif
        end
    end

    assign load   = load_q;
    assign datain = data_q;
    assign rxerr  = err_q;

endmodule

// File: rtl/uart_link.sv
// uart_link: full-duplex UART; receiver in uart_link_rx, transmitter FSM here.
// Optional feature macro: UART_LINK_PARITY_EN (even-parity bit between data and stop).
module uart_link
    import uart_link_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD       = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    uart_link_if.master bus
);
    localparam int unsigned CPB = clks_per_bit(CLOCK_FREQ, BAUD);
    localparam int unsigned CW  = $clog2(CPB);
    localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);

    logic       rx_load;
    logic [7:0] rx_data;
    logic       rx_err;

    uart_link_rx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD       (BAUD)
    ) u_rx (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .load   (rx_load),
        .datain (rx_data),
        .rxerr  (rx_err)
    );

    assign bus.load   = rx_load;
    assign bus.datain = rx_data;
    assign bus.rxerr  = rx_err;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
`ifdef UART_LINK_PARITY_EN
    logic          par_q, par_d;
`endif

    // TX next-state; txd is registered from the next state so the line changes with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_LINK_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            T_IDLE: begin
                cnt_d = '0;
                if (bus.enout) begin
                    shift_d = bus.dataout;
`ifdef UART_LINK_PARITY_EN
                    par_d   = even_parity(bus.dataout);
`endif
                    bit_d   = '0;
                    state_d = T_START;
                end
            end
            T_START: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = T_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            T_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_LINK_PARITY_EN
                        state_d = T_PARITY;
`else
                        state_d = T_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_LINK_PARITY_EN
            T_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = T_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            T_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = T_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            T_WAIT: begin
                cnt_d = '0;
                if (!bus.enout) begin
                    state_d = T_IDLE;
                end
            end
            default: begin
                state_d = T_IDLE;
                cnt_d   = '0;
            end
        endcase

        unique case (state_d)
            T_START:  txd_d = 1'b0;
            T_DATA:   txd_d = shift_d[0];
`ifdef UART_LINK_PARITY_EN
            T_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // TX state and line register; reset aborts any frame and drives the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_LINK_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_LINK_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd       = txd_q;
    assign bus.ready = (state_q == T_IDLE);

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: scoreboard bench for uart_link at 10 clocks per bit.
// Honours UART_LINK_PARITY_EN when defined for the build.
module tb_uart_link;
    localparam int unsigned CPB = 10;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic txd;

    uart_link_if bus_if ();

    uart_link #(
        .CLOCK_FREQ (1_000_000),
        .BAUD       (100_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .txd   (txd),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned load_cnt = 0;
    int unsigned rxerr_cnt = 0;
    int unsigned tx_frames = 0;
    int unsigned last_load_cyc = 0;
    bit          tx_mon_en = 1'b1;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RX scoreboard: every load pops one expected byte; rxerr cycles are counted.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus_if.load === 1'b1) begin
                load_cnt++;
                last_load_cyc = cyc;
                if (rx_exp.size() == 0) check("rx_unexpected_load", 32'd1, 32'd0);
                else check("rx_data", 32'(bus_if.datain), 32'(rx_exp.pop_front()));
            end
            if (bus_if.rxerr === 1'b1) rxerr_cnt++;
        end
    end

    // TX line decoder: samples each bit mid-period and pops the expected byte at the stop bit.
    initial begin : tx_monitor
        logic [7:0] got;
        got = '0;
        forever begin
            @(negedge clk);
            if (tx_mon_en && reset === 1'b0 && txd === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                check("tx_start_bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = txd;
                end
`ifdef UART_LINK_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (tx_exp.size() != 0) check("tx_parity_bit", 32'(txd), 32'(^tx_exp[0]));
`endif
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", 32'(txd), 32'd1);
                tx_frames++;
                if (tx_exp.size() == 0) check("tx_unexpected_frame", 32'd1, 32'd0);
                else check("tx_data", 32'(got), 32'(tx_exp.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge; leaves the line idle-high afterwards.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        if (stop_bit && !par_flip) rx_exp.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_LINK_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    task automatic start_tx(input logic [7:0] b, input int unsigned hold, input bit expect_frame);
        if (expect_frame) tx_exp.push_back(b);
        bus_if.enout   = 1'b1;
        bus_if.dataout = b;
        repeat (hold) @(posedge clk);
        #1;
        bus_if.enout = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int unsigned max_cycles);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (bus_if.ready !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus_if.ready), 32'd1);
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int unsigned c0;
        int unsigned l0;
        int unsigned e0;
        int unsigned exp_frames;

        reset = 1'b1;
        rxd = 1'b1;
        bus_if.enout = 1'b0;
        bus_if.dataout = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_ready", 32'(bus_if.ready), 32'd1);
        check("reset_load", 32'(bus_if.load), 32'd0);
        check("reset_rxerr", 32'(bus_if.rxerr), 32'd0);
        check("reset_datain", 32'(bus_if.datain), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(5);

        // Single good frame with latency window.
        c0 = cyc;
        l0 = load_cnt;
        e0 = rxerr_cnt;
        send_rx(8'hA5, 1'b1, 1'b0);
        idle_cycles(5);
        check("rx_a5_loads", 32'(load_cnt - l0), 32'd1);
        check("rx_a5_no_err", 32'(rxerr_cnt - e0), 32'd0);
        check("rx_a5_latency_ok", 32'(last_load_cyc - c0 >= 90 && last_load_cyc - c0 <= 102), 32'd1);
        check("rx_a5_datain", 32'(bus_if.datain), 32'hA5);

        // Short low glitch is rejected silently.
        l0 = load_cnt;
        e0 = rxerr_cnt;
        rxd = 1'b0;
        idle_cycles(3);
        rxd = 1'b1;
        idle_cycles(30);
        check("glitch_no_load", 32'(load_cnt - l0), 32'd0);
        check("glitch_no_err", 32'(rxerr_cnt - e0), 32'd0);
        check("glitch_datain_kept", 32'(bus_if.datain), 32'hA5);

        // Back-to-back frames with no idle gap.
        l0 = load_cnt;
        send_rx(8'h12, 1'b1, 1'b0);
        send_rx(8'h34, 1'b1, 1'b0);
        idle_cycles(5);
        check("rx_b2b_loads", 32'(load_cnt - l0), 32'd2);

        // Framing error: stop bit low.
        l0 = load_cnt;
        e0 = rxerr_cnt;
        send_rx(8'h3C, 1'b0, 1'b0);
        idle_cycles(30);
        check("rx_stop0_err", 32'(rxerr_cnt - e0), 32'd1);
        check("rx_stop0_no_load", 32'(load_cnt - l0), 32'd0);
        check("rx_stop0_datain_kept", 32'(bus_if.datain), 32'h34);

        // TX single frame with enout held two cycles.
        tx_exp.push_back(8'h81);
        bus_if.enout = 1'b1;
        bus_if.dataout = 8'h81;
        @(negedge clk);
        check("tx81_ready_before", 32'(bus_if.ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("tx81_ready_low", 32'(bus_if.ready), 32'd0);
        @(posedge clk);
        #1;
        bus_if.enout = 1'b0;
        wait_ready("tx81_ready_return", 200);
        idle_cycles(150);
        check("tx81_one_frame", 32'(tx_frames), 32'd1);

        // Full duplex.
        l0 = load_cnt;
        fork
            start_tx(8'h55, 1, 1'b1);
            send_rx(8'hC3, 1'b1, 1'b0);
        join
        wait_ready("duplex_ready_return", 200);
        idle_cycles(5);
        check("duplex_rx_loads", 32'(load_cnt - l0), 32'd1);
        check("duplex_datain", 32'(bus_if.datain), 32'hC3);
        exp_frames = 2;

`ifdef UART_LINK_PARITY_EN
        start_tx(8'h07, 1, 1'b1);
        wait_ready("par_tx_ready_return", 250);
        exp_frames = 3;
        l0 = load_cnt;
        e0 = rxerr_cnt;
        send_rx(8'h07, 1'b1, 1'b1);
        idle_cycles(10);
        check("par_rx_err", 32'(rxerr_cnt - e0), 32'd1);
        check("par_rx_no_load", 32'(load_cnt - l0), 32'd0);
        check("par_rx_datain_kept", 32'(bus_if.datain), 32'hC3);
`endif
        idle_cycles(20);
        check("tx_frame_count", 32'(tx_frames), 32'(exp_frames));

        // Reset in the middle of a transmitted frame.
        tx_mon_en = 1'b0;
        start_tx(8'hF0, 1, 1'b0);
        idle_cycles(34);
        check("rst_tx_mid_low", 32'(txd), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_txd", 32'(txd), 32'd1);
        check("rst_tx_ready", 32'(bus_if.ready), 32'd1);
        check("rst_datain_cleared", 32'(bus_if.datain), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(150);
        check("rst_txd_stays_idle", 32'(txd), 32'd1);

        check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);
        check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
